// File: rtl/fetch_queue_if.sv
// Instruction-memory and dispatch-side signals of the fetch front end.
// master = fetch_queue, slave = imem model / dispatch stage.
interface fetch_queue_if #(
    parameter int PC_WIDTH = 64
);
    logic                out_imem_req;
    logic [PC_WIDTH-1:0] out_imem_addr;
    logic [31:0]         in_imem_rdata;
    logic                out_valid;
    logic [31:0]         out_insnbits;
    logic [PC_WIDTH-1:0] out_pc;
    logic                in_stall;
    logic                in_redirect;
    logic [PC_WIDTH-1:0] in_redirect_pc;
    logic                out_fetch_done;

    modport master (
        output out_imem_req, out_imem_addr, out_valid, out_insnbits, out_pc, out_fetch_done,
        input  in_imem_rdata, in_stall, in_redirect, in_redirect_pc
    );

    modport slave (
        input  out_imem_req, out_imem_addr, out_valid, out_insnbits, out_pc, out_fetch_done,
        output in_imem_rdata, in_stall, in_redirect, in_redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC owner, single-outstanding imem reader and in-order FIFO.
// Optional macro FETCH_STATIC_B_EN: follow unconditional B in the fetch stage (one bubble).
module fetch_queue #(
    parameter int QUEUE_DEPTH = 4,
    parameter int PC_WIDTH    = 64
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic [PC_WIDTH-1:0] in_start_pc,
    fetch_queue_if.master       bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] pc_r, pc_nx;
    logic                if_valid_r, if_valid_nx;
    logic [PC_WIDTH-1:0] if_pc_r, if_pc_nx;
    logic                halted_r, halted_nx;
    logic [PTR_W-1:0]    head_r, head_nx;
    logic [PTR_W-1:0]    tail_r, tail_nx;
    logic [CNT_W-1:0]    count_r, count_nx;

    logic [31:0]         mem_insn_r [QUEUE_DEPTH];
    logic [PC_WIDTH-1:0] mem_pc_r   [QUEUE_DEPTH];

    logic                valid_r, valid_nx;
    logic [31:0]         insn_r, insn_nx;
    logic [PC_WIDTH-1:0] head_pc_r, head_pc_nx;
    logic                done_r, done_nx;

    logic [CNT_W:0]      occ_s;
    logic                req_s;
    logic                push_s;
    logic                pop_s;
    logic                is_hlt_s;

    function automatic logic hlt_match(input logic [31:0] word);
        return (word & 32'hFFE0_001F) == 32'hD440_0000;
    endfunction

    // Issue/push/pop qualifiers; occupancy deliberately ignores a same-cycle pop.
    always_comb begin
        occ_s    = {1'b0, count_r} + {{CNT_W{1'b0}}, if_valid_r};
        req_s    = !in_rst && !halted_r && !bus.in_redirect && (occ_s < (CNT_W+1)'(QUEUE_DEPTH));
        push_s   = if_valid_r && !in_rst && !bus.in_redirect;
        pop_s    = valid_r && !bus.in_stall && !in_rst && !bus.in_redirect;
        is_hlt_s = hlt_match(bus.in_imem_rdata);
    end

    // Next-state for PC, in-flight tracking, halt flag and FIFO pointers.
    always_comb begin
        pc_nx       = pc_r;
        if_valid_nx = if_valid_r;
        if_pc_nx    = if_pc_r;
        halted_nx   = halted_r;
        head_nx     = head_r;
        tail_nx     = tail_r;
        count_nx    = count_r;
        if (bus.in_redirect) begin
            pc_nx       = bus.in_redirect_pc & ~(PC_WIDTH'(3));
            if_valid_nx = 1'b0;
            halted_nx   = 1'b0;
            head_nx     = {PTR_W{1'b0}};
            tail_nx     = {PTR_W{1'b0}};
            count_nx    = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tail_nx = tail_r + PTR_W'(1);
            end else begin
                tail_nx = tail_r;
            end
            if (pop_s) begin
                head_nx = head_r + PTR_W'(1);
            end else begin
                head_nx = head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nx = count_r + CNT_W'(1);
                2'b01:   count_nx = count_r - CNT_W'(1);
                default: count_nx = count_r;
            endcase
            if (push_s && is_hlt_s) begin
                halted_nx = 1'b1;
            end else begin
                halted_nx = halted_r;
            end
            if (req_s) begin
                if_pc_nx = pc_r;
            end else begin
                if_pc_nx = if_pc_r;
            end
`ifdef FETCH_STATIC_B_EN
            // A taken B retargets the PC and kills whatever was issued alongside it.
            if (push_s && (bus.in_imem_rdata[31:26] == 6'b000101)) begin
                pc_nx       = if_pc_r + {{(PC_WIDTH-28){bus.in_imem_rdata[25]}},
                                         bus.in_imem_rdata[25:0], 2'b00};
                if_valid_nx = 1'b0;
            end else if (req_s) begin
                pc_nx       = pc_r + PC_WIDTH'(4);
                if_valid_nx = 1'b1;
            end else begin
                pc_nx       = pc_r;
                if_valid_nx = 1'b0;
            end
`else
            if (req_s) begin
                pc_nx       = pc_r + PC_WIDTH'(4);
                if_valid_nx = 1'b1;
            end else begin
                pc_nx       = pc_r;
                if_valid_nx = 1'b0;
            end
`endif
        end
    end

    // Registered head view: a push lands at the head only when it is the sole entry next cycle.
    always_comb begin
        valid_nx   = (count_nx != {CNT_W{1'b0}});
        insn_nx    = 32'h0000_0000;
        head_pc_nx = {PC_WIDTH{1'b0}};
        if (!valid_nx) begin
            insn_nx    = 32'h0000_0000;
            head_pc_nx = {PC_WIDTH{1'b0}};
        end else if (push_s && (count_nx == CNT_W'(1))) begin
            insn_nx    = bus.in_imem_rdata;
            head_pc_nx = if_pc_r;
        end else begin
            insn_nx    = mem_insn_r[head_nx];
            head_pc_nx = mem_pc_r[head_nx];
        end
        done_nx = halted_nx && (count_nx == {CNT_W{1'b0}}) && !if_valid_nx;
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            pc_r       <= in_start_pc & ~(PC_WIDTH'(3));
            if_valid_r <= 1'b0;
            if_pc_r    <= {PC_WIDTH{1'b0}};
            halted_r   <= 1'b0;
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            valid_r    <= 1'b0;
            insn_r     <= 32'h0000_0000;
            head_pc_r  <= {PC_WIDTH{1'b0}};
            done_r     <= 1'b0;
        end else begin
            pc_r       <= pc_nx;
            if_valid_r <= if_valid_nx;
            if_pc_r    <= if_pc_nx;
            halted_r   <= halted_nx;
            head_r     <= head_nx;
            tail_r     <= tail_nx;
            count_r    <= count_nx;
            valid_r    <= valid_nx;
            insn_r     <= insn_nx;
            head_pc_r  <= head_pc_nx;
            done_r     <= done_nx;
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge in_clk) begin
        if (push_s) begin
            mem_insn_r[tail_r] <= bus.in_imem_rdata;
            mem_pc_r[tail_r]   <= if_pc_r;
        end
    end

    assign bus.out_imem_req   = req_s;
    assign bus.out_imem_addr  = pc_r;
    assign bus.out_valid      = valid_r;
    assign bus.out_insnbits   = insn_r;
    assign bus.out_pc         = head_pc_r;
    assign bus.out_fetch_done = done_r;
endmodule
